// File: rtl/sra_operand_feeder.sv
// Operand feeder for the SRA datapath: buffers signed operand pairs in a small FIFO
// and issues one pair per FRAME-cycle operation frame, holding it stable for the frame.
module sra_operand_feeder #(
    parameter int MSB   = 15,
    parameter int DEPTH = 4,
    parameter int FRAME = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [MSB:0]             in_a,
    input  logic [MSB:0]             in_b,
    output logic [MSB:0]             In1,
    output logic [MSB:0]             In2,
    output logic                     op_start,
    output logic                     frame_last,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FRAME);
    localparam logic [FW-1:0] FCNT_LAST = FW'(FRAME - 1);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [MSB:0]    mem_a [DEPTH];
    logic [MSB:0]    mem_b [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [0:0]      state;
    logic [FW-1:0]   fcnt;
    logic            push;
    logic            pop;
    logic            frame_end;

    // Handshake: a pair transfers on a rising edge where in_valid && in_ready.
    // in_ready depends only on occupancy, so a full FIFO never accepts even when popping.
    assign in_ready  = reset && (count < FULL);
    assign push      = in_valid && in_ready;
    assign frame_end = (state == RUN) && (fcnt == FCNT_LAST);
    // Decisions use pre-edge occupancy; a same-edge push is seen one edge later.
    assign pop       = (count != '0) && ((state == IDLE) || frame_end);

    assign busy       = (state == RUN);
    assign frame_last = frame_end;
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            fcnt     <= '0;
            op_start <= 1'b0;
            In1      <= '0;
            In2      <= '0;
        end else begin
            op_start <= 1'b0;
            if (pop) begin
                In1      <= mem_a[rd_ptr];
                In2      <= mem_b[rd_ptr];
                op_start <= 1'b1;
                fcnt     <= '0;
                state    <= RUN;
            end else if (state == RUN) begin
                if (frame_end) begin
                    state <= IDLE;
                    fcnt  <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sra_operand_feeder.sv
// Directed bench for sra_operand_feeder: scenario checks plus an issue-order
// scoreboard and per-cycle frame monitor.
module tb_sra_operand_feeder;

    localparam int MSB   = 15;
    localparam int DEPTH = 4;
    localparam int FRAME = 5;
    localparam int W     = MSB + 1;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic [W-1:0]   In1;
    logic [W-1:0]   In2;
    logic           op_start;
    logic           frame_last;
    logic           busy;
    logic [$clog2(DEPTH):0] fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] held;
    int             fc = 0;
    int             max_count = 0;
    bit             saw_stall = 1'b0;

    sra_operand_feeder #(.MSB(MSB), .DEPTH(DEPTH), .FRAME(FRAME)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .In1(In1), .In2(In2),
        .op_start(op_start), .frame_last(frame_last), .busy(busy),
        .fifo_count(fifo_count)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one pair and hold it until it transfers; returns just after the accepting edge.
    task automatic push_one(input logic [W-1:0] a, input logic [W-1:0] b);
        bit accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 200 && !accepted; i++) begin
            accepted = in_ready;
            if (!in_ready) saw_stall = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("push_accept", 32'(accepted), 32'd1);
        if (accepted) exp_q.push_back({a, b});
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            tick();
        end
        check("drain_done", 32'(exp_q.size() == 0 && !busy), 32'd1);
    endtask

    // Scoreboard and frame monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
            if (op_start) begin
                fc = 0;
                held = {In1, In2};
                if (exp_q.size() == 0) check("unexpected_issue", {In1, In2}, 32'hFFFF_FFFF);
                else check("issue_order", {In1, In2}, exp_q.pop_front());
            end else if (busy) begin
                fc++;
                check("operand_hold", {In1, In2}, held);
            end
            check("frame_last", 32'(frame_last), 32'(busy && fc == FRAME - 1));
        end
    end

    initial begin
        // Reset held low for two cycles
        tick(2);
        check("rst_In1", 32'(In1), 32'd0);
        check("rst_In2", 32'(In2), 32'd0);
        check("rst_op_start", 32'(op_start), 32'd0);
        check("rst_frame_last", 32'(frame_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);

        // Single operation: latency one cycle, frame of five cycles
        push_one(16'd77, -16'sd50);
        check("single_count", 32'(fifo_count), 32'd1);
        check("single_idle", 32'(busy), 32'd0);
        tick();
        check("single_op_start", 32'(op_start), 32'd1);
        check("single_In1", 32'(In1), 32'd77);
        check("single_In2", 32'(In2), 32'h0000_FFCE);
        tick(3);
        check("single_not_last", 32'(frame_last), 32'd0);
        tick();
        check("single_last", 32'(frame_last), 32'd1);
        tick();
        check("single_busy_off", 32'(busy), 32'd0);

        // Back-to-back: frames at t, t+5, t+10
        push_one(16'd77, -16'sd50);
        push_one(16'd154, -16'sd100);
        push_one(16'd231, -16'sd150);
        tick(3);
        check("b2b_last1", 32'(frame_last), 32'd1);
        tick();
        check("b2b_start2", 32'(op_start), 32'd1);
        check("b2b_In1_2", 32'(In1), 32'd154);
        tick(4);
        check("b2b_last2", 32'(frame_last), 32'd1);
        tick();
        check("b2b_start3", 32'(op_start), 32'd1);
        check("b2b_In1_3", 32'(In1), 32'd231);
        tick(4);
        check("b2b_last3", 32'(frame_last), 32'd1);
        check("b2b_busy3", 32'(busy), 32'd1);
        tick();
        check("b2b_idle", 32'(busy), 32'd0);

        // Full FIFO: six pairs back to back, sixth stalls until a pop
        max_count = 0;
        saw_stall = 1'b0;
        for (int i = 0; i < 6; i++) push_one(16'(100 + i), 16'(-200 - i));
        check("full_max_count", 32'(max_count), 32'd4);
        check("full_stall_seen", 32'(saw_stall), 32'd1);
        drain();

        // Pointer wrap: nine distinct pairs
        max_count = 0;
        for (int i = 0; i < 9; i++) push_one(16'(1000 + 17 * i), 16'(-3 * i - 1));
        drain();
        check("wrap_max_count", 32'(max_count <= DEPTH), 32'd1);

        // Late push on the edge where the frame ends with an empty FIFO
        push_one(16'd500, 16'd501);
        tick(5);
        check("late_last", 32'(frame_last), 32'd1);
        push_one(16'd600, -16'sd601);
        check("late_idle", 32'(busy), 32'd0);
        check("late_count", 32'(fifo_count), 32'd1);
        tick();
        check("late_op_start", 32'(op_start), 32'd1);
        check("late_In1", 32'(In1), 32'd600);
        drain();

        // Reset mid-frame with extreme operands
        push_one(16'h8000, 16'h7FFF);
        push_one(16'd1, 16'd1);
        tick(2);
        reset = 1'b0;
        tick();
        exp_q.delete();
        check("midrst_In1", 32'(In1), 32'd0);
        check("midrst_In2", 32'(In2), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(fifo_count), 32'd0);
        reset = 1'b1;
        tick(3);
        check("midrst_stay_idle", 32'(busy), 32'd0);
        push_one(16'h8000, 16'h7FFF);
        tick();
        check("extreme_In1", 32'(In1), 32'h0000_8000);
        check("extreme_In2", 32'(In2), 32'h0000_7FFF);
        drain();
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sra_operand_feeder.md
# sra_operand_feeder

Upstream operand stage for the SRA datapath and controller pair. It accepts signed operand pairs over a valid/ready handshake and buffers them in a small FIFO. It presents one pair on `In1`/`In2` for exactly one operation frame of `FRAME` clock cycles, holding the operands stable for the whole frame. It marks frame boundaries with `op_start` and `frame_last`, so the downstream datapath receives new operands only at frame boundaries.

## Interface
- `MSB`, default 15: operand MSB index; operands are `MSB+1` bits, two's complement.
- `DEPTH`, default 4: FIFO depth in entries; must be a power of 2, at least 2.
- `FRAME`, default 5: datapath operation length in cycles; must be at least 2.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  upstream offers `in_a`/`in_b`.
- `in_ready`  output  1  FIFO can accept this cycle.
- `in_a`  input  `MSB+1`  signed operand A.
- `in_b`  input  `MSB+1`  signed operand B.
- `In1`  output  `MSB+1`  registered operand A to the datapath.
- `In2`  output  `MSB+1`  registered operand B to the datapath.
- `op_start`  output  1  one-cycle pulse in the first cycle of a frame.
- `frame_last`  output  1  high in the last cycle of a frame.
- `busy`  output  1  a frame is in progress.
- `fifo_count`  output  `clog2(DEPTH)+1`  current FIFO occupancy.

## Operation
- **FIFO.** Circular buffer with write and read pointers and an occupancy counter.
  - `in_ready = reset && (fifo_count < DEPTH)`, combinational.
  - A push occurs when `in_valid && in_ready` at the edge.
  - Full FIFO: `in_ready` is 0 even if a pop happens in the same cycle. There is no fall-through.
  - Simultaneous push and pop when not full: occupancy is unchanged, both pointers advance, and the pointers wrap modulo `DEPTH`.
- **FSM**, states IDLE and RUN, with frame counter `fcnt` in the range 0..FRAME-1.
  - **IDLE**, `fifo_count > 0` at the edge:
    - pop the head and load it into `In1`/`In2`;
    - `op_start <= 1`, `fcnt <= 0`, go to RUN.
  - **IDLE**, `fifo_count == 0`: stay in IDLE; `In1`/`In2` hold their last values.
  - **RUN**, `fcnt < FRAME-1`: `fcnt` increments, `op_start <= 0`.
  - **RUN**, `fcnt == FRAME-1`, `fifo_count > 0`: pop and load the next pair, `op_start <= 1`, `fcnt <= 0`, stay in RUN. Frames run back to back with no gap.
  - **RUN**, `fcnt == FRAME-1`, `fifo_count == 0`: go to IDLE.
- **Decision timing.** The FSM uses the pre-edge `fifo_count`. A push on the same edge as a frame-end or IDLE decision is not seen until the next edge.
- **Outputs.**
  - `busy = (state == RUN)`.
  - `frame_last = busy && (fcnt == FRAME-1)`.
- **Data path.** Operands are copied bit-exact with no arithmetic; sign is preserved.
- **Reset.** When `reset == 0` at an edge:
  - FIFO is emptied and the pointers zeroed;
  - FSM goes to IDLE, `fcnt = 0`;
  - `In1 = 0`, `In2 = 0`.
  - Reset mid-frame aborts the frame and discards all buffered entries.

## Timing
- Reset values:
  - `In1 = 0`, `In2 = 0`;
  - `op_start = 0`, `frame_last = 0`, `busy = 0`;
  - `fifo_count = 0`;
  - `in_ready = 0` while `reset` is low, 1 on the first cycle after release.
- Latency from IDLE: a pair accepted at edge E0 appears on `In1`/`In2` with `op_start = 1` after edge E1, which is one cycle of latency.
- Operands are stable for exactly `FRAME` cycles, from the `op_start` cycle through the `frame_last` cycle.
- Back-to-back period is `FRAME` cycles. `op_start` in the cycle after `frame_last` means continuous issue.
- Restart from IDLE costs one idle cycle: `busy = 0` for at least one cycle between frames.
- Sustained throughput is one pair per `FRAME` cycles. The FIFO absorbs bursts up to `DEPTH` entries.

## Test plan
- **Single operation.** Reset low for 2 cycles, then push A=77, B=-50 once.
  - Next cycle: `In1 = 77`, `In2 = -50`, `op_start = 1`.
  - `frame_last` is high 4 cycles later.
  - The cycle after that: `busy = 0`.
- **Back-to-back.** Push (77,-50), (154,-100), (231,-150) on consecutive cycles.
  - Three frames with `op_start` at cycles t, t+5, t+10.
  - Each pair is held for 5 cycles; IDLE is entered only after the third `frame_last`.
- **Full FIFO.** Hold `in_valid` high for 6 pairs with the datapath busy.
  - `fifo_count` reaches 4 and `in_ready` drops.
  - The stalled pair is accepted when the next pop occurs; there is no loss or duplication, and issue order equals push order.
- **Pointer wrap.** Push and issue 9 distinct pairs.
  - Outputs are in order across two pointer wraps.
  - `fifo_count` never exceeds 4.
- **Late push.** Push a pair exactly on the edge where a RUN frame ends with an empty FIFO.
  - FSM enters IDLE for one cycle, then issues the new pair with `op_start`.
- **Reset mid-frame and extremes.** Push (-32768, 32767) and (1,1), then assert reset at `fcnt = 2`.
  - `In1 = In2 = 0`, `busy = 0`, `fifo_count = 0`; the (1,1) pair is never issued.
  - Repushing (-32768, 32767) yields the exact bit patterns 0x8000 and 0x7FFF.
